// File: rtl/cycbpuf_pkg.sv
// cycbpuf_pkg: FSM state encoding and default parameters for the cyclic BPUF engine
package cycbpuf_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, SAMPLE, DONE} state_t;
  localparam int DEF_N_CELLS = 51;
  localparam int DEF_N_CYC = 25;
  localparam int DEF_RESP_W = 8;
  localparam int DEF_SETTLE_CYC = 16;
endpackage

// File: rtl/cycbpuf_array.sv
// cycbpuf_array: BPUF cells, cross-coupled cyclic feedback ring and output parity
module cycbpuf_cell (
  input  logic clk,
  input  logic excite,
  output logic q
);
  always_ff @(posedge clk) q <= excite;
endmodule

module cycbpuf_array #(
  parameter int N_CELLS = 51,
  parameter int N_CYC = 25
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [N_CELLS-1:0] wchal,
  output logic               parity
);
  logic [N_CELLS-1:0] q, excite;
  logic [N_CYC-1:0] cycle_q, cycle_d;
  for (genvar i = 0; i < N_CELLS; i++) begin : g_cell
    if (i < N_CYC) begin : g_cyc
      assign cycle_d[i] = en ? wchal[i] ^ q[N_CYC-1-i] : 1'b0;
      assign excite[i] = rst_n & cycle_q[i];
    end else begin : g_dir
      assign excite[i] = rst_n & en & wchal[i];
    end
    cycbpuf_cell u_cell (.clk(clk), .excite(excite[i]), .q(q[i]));
  end
  always_ff @(posedge clk)
    if (!rst_n) cycle_q <= '0;
    else cycle_q <= cycle_d;
  assign parity = ^q;
endmodule

// File: rtl/cycbpuf_eval_engine.sv
// cycbpuf_eval_engine: sequences RESP_W load/settle/sample rounds over the BPUF array
module cycbpuf_eval_engine
  import cycbpuf_pkg::*;
#(
  parameter int N_CELLS = DEF_N_CELLS,
  parameter int N_CYC = DEF_N_CYC,
  parameter int RESP_W = DEF_RESP_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_CELLS-1:0] chal,
  output logic               busy,
  output logic               resp_valid,
  output logic [RESP_W-1:0]  resp
);
  localparam int KW = RESP_W > 1 ? $clog2(RESP_W) : 1;
  localparam int SW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  if (N_CYC < 1 || N_CYC > N_CELLS || SETTLE_CYC < 1 || RESP_W < 1) begin : g_bad_params
    $error("cycbpuf_eval_engine: illegal parameter combination");
  end
  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [N_CELLS-1:0] chal_q, chal_d, wchal_q, wchal_d;
  logic [RESP_W-1:0] shift_q, shift_d, resp_q, resp_d;
  logic valid_q, valid_d, parity, last;
  int sh;
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    cnt_d = cnt_q;
    chal_d = chal_q;
    wchal_d = wchal_q;
    shift_d = shift_q;
    resp_d = resp_q;
    valid_d = 1'b0;
    sh = int'(k_q) % N_CELLS;
    last = k_q == KW'(RESP_W - 1);
    case (state_q)
      IDLE: if (start) begin
        chal_d = chal;
        k_d = '0;
        state_d = LOAD;
      end
      LOAD: begin
        wchal_d = (chal_q << sh) | (chal_q >> (N_CELLS - sh));
        cnt_d = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q == SW'(SETTLE_CYC - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == SW'(SETTLE_CYC - 1) ? SAMPLE : SETTLE;
      end
      SAMPLE: begin
        shift_d[k_q] = parity;
        k_d = last ? k_q : k_q + 1'b1;
        state_d = last ? DONE : LOAD;
      end
      DONE: begin
        resp_d = shift_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      k_q <= '0;
      cnt_q <= '0;
      chal_q <= '0;
      wchal_q <= '0;
      shift_q <= '0;
      resp_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      cnt_q <= cnt_d;
      chal_q <= chal_d;
      wchal_q <= wchal_d;
      shift_q <= shift_d;
      resp_q <= resp_d;
      valid_q <= valid_d;
    end
  (* keep = "true", allow_combinational_loops = "true" *)
  cycbpuf_array #(.N_CELLS(N_CELLS), .N_CYC(N_CYC)) u_array (
    .clk(clk),
    .rst_n(rst_n),
    .en(state_q == SETTLE),
    .wchal(wchal_q),
    .parity(parity)
  );
  assign busy = state_q != IDLE;
  assign resp_valid = valid_q;
  assign resp = resp_q;
endmodule

// File: tb/tb_cycbpuf_eval_engine.sv
// tb_cycbpuf_eval_engine: randomized self-checking bench against a behavioural BPUF model
module tb_cycbpuf_eval_engine;
  localparam int NC = 51;
  localparam int NY = 25;
  localparam int RW = 4;
  localparam int SC = 2;
  localparam int LAT = RW * (SC + 2) + 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [NC-1:0] chal = '0;
  logic busy, resp_valid;
  logic [RW-1:0] resp;
  int checks = 0;
  int failures = 0;

  cycbpuf_eval_engine #(.N_CELLS(NC), .N_CYC(NY), .RESP_W(RW), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .chal(chal),
    .busy(busy), .resp_valid(resp_valid), .resp(resp)
  );

  always #5 clk = ~clk;

  // Each round excites a freshly cleared array with the challenge rotated left by the round index.
  function automatic logic [RW-1:0] model(input logic [NC-1:0] c);
    logic [RW-1:0] r;
    logic [NC-1:0] w, q, qn;
    logic [NY-1:0] cy, cyn;
    r = '0;
    w = c;
    for (int k = 0; k < RW; k++) begin
      q = '0;
      cy = '0;
      for (int s = 0; s < SC; s++) begin
        for (int i = 0; i < NC; i++) qn[i] = (i < NY) ? cy[i] : w[i];
        for (int i = 0; i < NY; i++) cyn[i] = w[i] ^ q[NY-1-i];
        q = qn;
        cy = cyn;
      end
      r[k] = ^q;
      w = {w[NC-2:0], w[NC-1]};
    end
    return r;
  endfunction

  function automatic logic [NC-1:0] rand_chal();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[NC-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one evaluation from an idle DUT; optional extra start pulses at cycles ra/rb.
  task automatic run_eval(input logic [NC-1:0] c, input int ra, input int rb,
                          output int lat, output int nval, output int bcnt, output logic [RW-1:0] r);
    start = 1'b1;
    chal = c;
    tick();
    start = 1'b0;
    chal = rand_chal();
    lat = -1;
    nval = 0;
    bcnt = 0;
    r = '0;
    for (int n = 1; n <= 30; n++) begin
      start = (n == ra || n == rb);
      tick();
      if (resp_valid) begin
        if (nval == 0) begin
          lat = n;
          r = resp;
        end
        nval++;
      end else if (lat < 0 && busy) bcnt++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || resp_valid !== 1'b0 || resp !== '0) begin
        failures++;
        $display("FAIL reset_hold: busy=%b valid=%b resp=%h required 0 0 0", busy, resp_valid, resp);
      end
    end
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || resp_valid !== 1'b0 || resp !== '0) begin
        failures++;
        $display("FAIL reset_idle: busy=%b valid=%b resp=%h required 0 0 0", busy, resp_valid, resp);
      end
    end
  endtask

  task automatic test_zero();
    int lat, nval, bcnt;
    logic [RW-1:0] r;
    run_eval('0, -1, -1, lat, nval, bcnt, r);
    checks++;
    if (lat !== LAT || nval !== 1) begin
      failures++;
      $display("FAIL zero_latency: lat=%0d pulses=%0d required %0d 1", lat, nval, LAT);
    end
    checks++;
    if (bcnt !== LAT - 1) begin
      failures++;
      $display("FAIL zero_busy: busy_cycles=%0d required %0d", bcnt, LAT - 1);
    end
    checks++;
    if (r !== '0) begin
      failures++;
      $display("FAIL zero_resp: resp=%h required 0", r);
    end
  endtask

  task automatic test_fixed();
    int lat, nval, bcnt;
    logic [RW-1:0] r1, r2;
    logic [NC-1:0] c;
    c = 51'h1_2345_6789_ABCD;
    run_eval(c, -1, -1, lat, nval, bcnt, r1);
    run_eval(c, -1, -1, lat, nval, bcnt, r2);
    checks++;
    if (r1 !== model(c)) begin
      failures++;
      $display("FAIL fixed_model: resp=%h required %h", r1, model(c));
    end
    checks++;
    if (r2 !== r1 || nval !== 1) begin
      failures++;
      $display("FAIL fixed_repeat: resp=%h pulses=%0d required %h 1", r2, nval, r1);
    end
  endtask

  task automatic test_random();
    int lat, nval, bcnt;
    logic [RW-1:0] r;
    logic [NC-1:0] c;
    for (int t = 0; t < 8; t++) begin
      c = rand_chal();
      run_eval(c, -1, -1, lat, nval, bcnt, r);
      checks++;
      if (r !== model(c) || lat !== LAT || nval !== 1) begin
        failures++;
        $display("FAIL random_eval: chal=%h resp=%h lat=%0d pulses=%0d required %h %0d 1",
                 c, r, lat, nval, model(c), LAT);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat, nval, bcnt;
    logic [RW-1:0] r;
    logic [NC-1:0] c;
    c = rand_chal();
    run_eval(c, 3, 10, lat, nval, bcnt, r);
    checks++;
    if (nval !== 1 || lat !== LAT) begin
      failures++;
      $display("FAIL ignore_start: pulses=%0d lat=%0d required 1 %0d", nval, lat, LAT);
    end
    checks++;
    if (r !== model(c)) begin
      failures++;
      $display("FAIL ignore_resp: resp=%h required %h", r, model(c));
    end
  endtask

  task automatic test_reset_mid();
    int lat, nval, bcnt, seen;
    logic [RW-1:0] r;
    run_eval(51'h1, -1, -1, lat, nval, bcnt, r);
    checks++;
    if (resp !== model(51'h1)) begin
      failures++;
      $display("FAIL mid_pre_resp: resp=%h required %h", resp, model(51'h1));
    end
    start = 1'b1;
    chal = rand_chal();
    tick();
    start = 1'b0;
    for (int n = 1; n <= SC + 3; n++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || resp !== '0) begin
      failures++;
      $display("FAIL mid_reset: busy=%b valid=%b resp=%h required 0 0 0", busy, resp_valid, resp);
    end
    seen = 0;
    for (int n = 0; n < 25; n++) begin
      tick();
      if (resp_valid || busy || resp !== '0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL mid_abort: activity_cycles=%0d required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int times[$];
    logic [RW-1:0] exp;
    logic [NC-1:0] c;
    c = rand_chal();
    exp = model(c);
    start = 1'b1;
    chal = c;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (n == 39) start = 1'b0;
      if (resp_valid) begin
        times.push_back(n);
        checks++;
        if (resp !== exp) begin
          failures++;
          $display("FAIL b2b_resp: resp=%h required %h", resp, exp);
        end
      end
    end
    checks++;
    if (times.size() !== 3) begin
      failures++;
      $display("FAIL b2b_count: pulses=%0d required 3", times.size());
    end
    for (int i = 1; i < times.size(); i++) begin
      checks++;
      if (times[i] - times[i-1] !== LAT + 1) begin
        failures++;
        $display("FAIL b2b_gap: gap=%0d required %0d", times[i] - times[i-1], LAT + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_fixed();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
